// File: rtl/pe_result_drain_if.sv
// Handshake bundle between the PE result capture stage and its producer/consumer.
// The slave modport is the drain stage itself; master is its environment.
interface pe_result_drain_if #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int SEQ_W  = 8,
  parameter int DROP_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_data;
  logic              in_en;
  logic [DATA_W-1:0] out_data;
  logic [SEQ_W-1:0]  out_seq;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              stat_clr;

  modport slave (
    input  in_data, in_en, out_ready, stat_clr,
    output out_data, out_seq, out_valid, level, overflow, drop_cnt
  );

  modport master (
    output in_data, in_en, out_ready, stat_clr,
    input  out_data, out_seq, out_valid, level, overflow, drop_cnt
  );
endinterface

// File: rtl/pe_result_drain.sv
// Captures PE results into a small tagged FIFO and drains them over valid/ready.
// The PE cannot stall, so results arriving at a full FIFO are dropped and counted.
module pe_result_drain #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int SEQ_W  = 8,
  parameter int DROP_W = 8
) (
  input  logic               clk,
  input  logic               rstn,
  pe_result_drain_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [SEQ_W-1:0]  mem_seq  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level_q;
  logic [SEQ_W-1:0]  seq_ctr;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;

  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  assign pop     = (level_q != '0) && bus.out_ready;
  assign full    = (level_q == FULL_LVL);
  // A pop frees the head slot in the same edge, so a full FIFO still accepts.
  assign push_ok = bus.in_en && (!full || pop);
  assign drop    = bus.in_en && full && !pop;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_seq[i]  <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      seq_ctr    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push_ok) begin
        mem_data[wr_ptr] <= bus.in_data;
        mem_seq[wr_ptr]  <= seq_ctr;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (bus.in_en) begin
        seq_ctr <= seq_ctr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (bus.stat_clr) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != '1) begin
          drop_q <= drop_q + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = mem_data[rd_ptr];
  assign bus.out_seq   = mem_seq[rd_ptr];
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_q;
endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: directed plan steps plus a random phase,
// every cycle compared against a queue-based reference model.
module tb_pe_result_drain;
  localparam int DEPTH = 4;

  logic clk;
  logic rstn;

  pe_result_drain_if #(.DATA_W(64), .DEPTH(DEPTH), .SEQ_W(8), .DROP_W(8)) bus ();

  pe_result_drain #(.DATA_W(64), .DEPTH(DEPTH), .SEQ_W(8), .DROP_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [63:0] mq_data [$];
  logic [7:0]  mq_seq  [$];
  logic [7:0]  m_seq;
  logic        m_ovf;
  int          m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_clear();
    mq_data.delete();
    mq_seq.delete();
    m_seq  = 8'd0;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  task automatic check_model();
    chk("valid", 64'(bus.out_valid), 64'(mq_data.size() != 0));
    chk("level", 64'(bus.level), 64'(mq_data.size()));
    chk("overflow", 64'(bus.overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
    if (mq_data.size() != 0) begin
      chk("out_data", bus.out_data, mq_data[0]);
      chk("out_seq", 64'(bus.out_seq), 64'(mq_seq[0]));
    end
  endtask

  // One clock: drive inputs at the falling edge, check, then advance the model at the rising edge.
  task automatic step(input logic en, input logic [63:0] d, input logic rdy,
                      input logic clr, input logic rst_n);
    int  sz;
    logic pop;
    logic dropped;
    @(negedge clk);
    bus.in_en     = en;
    bus.in_data   = d;
    bus.out_ready = rdy;
    bus.stat_clr  = clr;
    rstn          = rst_n;
    check_model();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      sz      = mq_data.size();
      pop     = (sz > 0) && rdy;
      dropped = 1'b0;
      if (pop) begin
        void'(mq_data.pop_front());
        void'(mq_seq.pop_front());
      end
      if (en) begin
        if (sz < DEPTH || pop) begin
          mq_data.push_back(d);
          mq_seq.push_back(m_seq);
        end else begin
          dropped = 1'b1;
        end
        m_seq = m_seq + 8'd1;
      end
      if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end else if (dropped) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    logic [7:0] prev_seq;
    logic       saw_wrap;
    logic       have_prev;

    rstn          = 1'b0;
    bus.in_en     = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.stat_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_level", 64'(bus.level), 64'd0);
    chk("rst_data", bus.out_data, 64'd0);
    chk("rst_seq", 64'(bus.out_seq), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_drop", 64'(bus.drop_cnt), 64'd0);

    // Single push with drain ready
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0, 1'b1);
    chk("p1_level", 64'(bus.level), 64'd1);
    chk("p1_data", bus.out_data, 64'h0123_4567_89AB_CDEF);
    chk("p1_seq", 64'(bus.out_seq), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("p1_empty", 64'(bus.out_valid), 64'd0);

    // Five pushes while stalled: one drop
    for (int i = 0; i < 5; i++) step(1'b1, rnd64(), 1'b0, 1'b0, 1'b1);
    chk("ovf_level", 64'(bus.level), 64'd4);
    chk("ovf_flag", 64'(bus.overflow), 64'd1);
    chk("ovf_cnt", 64'(bus.drop_cnt), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, rnd64(), 1'b0, 1'b0, 1'b1);
    chk("gap_seq", 64'(bus.out_seq), 64'd6);
    step(1'b0, '0, 1'b1, 1'b1, 1'b1);

    // Full FIFO with concurrent push and pop
    for (int i = 0; i < 4; i++) step(1'b1, rnd64(), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, rnd64(), 1'b1, 1'b0, 1'b1);
    chk("full_pp_level", 64'(bus.level), 64'd4);
    chk("full_pp_drop", 64'(bus.drop_cnt), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // 300 pushes with continuous drain: sequence wraps
    saw_wrap  = 1'b0;
    have_prev = 1'b0;
    prev_seq  = '0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, rnd64(), 1'b1, 1'b0, 1'b1);
      if (bus.out_valid) begin
        if (have_prev && prev_seq == 8'd255 && bus.out_seq == 8'd0) saw_wrap = 1'b1;
        prev_seq  = bus.out_seq;
        have_prev = 1'b1;
      end
    end
    chk("seq_wrap", 64'(saw_wrap), 64'd1);
    chk("stream_drop", 64'(bus.drop_cnt), 64'd0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);

    // 260 drops while stalled: counter saturates, then clear wins over a drop
    for (int i = 0; i < 264; i++) step(1'b1, rnd64(), 1'b0, 1'b0, 1'b1);
    chk("sat_cnt", 64'(bus.drop_cnt), 64'd255);
    chk("sat_ovf", 64'(bus.overflow), 64'd1);
    step(1'b1, rnd64(), 1'b0, 1'b1, 1'b1);
    chk("clr_ovf", 64'(bus.overflow), 64'd0);
    chk("clr_cnt", 64'(bus.drop_cnt), 64'd0);
    chk("clr_level", 64'(bus.level), 64'd4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(0, 99) < 60), rnd64(),
           logic'($urandom_range(0, 99) < 50),
           logic'($urandom_range(0, 99) < 3), 1'b1);
    end

    // Reset with three entries queued
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, rnd64(), 1'b0, 1'b0, 1'b1);
    chk("pre_rst_level", 64'(bus.level), 64'd3);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_level", 64'(bus.level), 64'd0);
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    step(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 1'b1);
    chk("post_rst_seq", 64'(bus.out_seq), 64'd0);
    chk("post_rst_data", bus.out_data, 64'hDEAD_BEEF_0000_0001);
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
